fir_core: RTL and testbench
===========================

// Module: fir_core
// PURPOSE
//  Compute engine downstream of the AXI slave. Takes its write strobes (a_wr/a_address_wr/a_data_out)
//  into control registers, coefficient and sample memories. On start, runs a Q1.15 FIR over the stored
//  samples with one sequential MAC, writes results to an output memory, and serves reads back to the
//  AXI read path. y[n] = sum_{k=0..NTAPS-1} h[k]*x[n-k], with x[i<0] = 0.
// PARAMETERS
//  ADDR_W       13    word-address width (matches the AXI slave)
//  DATA_W       16    data/sample/coefficient width, Q1.15 signed
//  MAX_TAPS     32    coefficient memory depth
//  MAX_SAMPLES  1024  sample/output memory depth
//  ACC_W        40    accumulator width (32-bit product + 8 guard bits)
// PORTS
//  a_clk        in   1       clock
//  a_rst_n      in   1       synchronous reset, active low
//  a_wr         in   1       write strobe from the AXI slave, 1 cycle per word
//  a_address_wr in   ADDR_W  write word address
//  a_data_out   in   DATA_W  write data
//  a_rd         in   1       read strobe from the AXI read path
//  a_address_rd in   ADDR_W  read word address
//  a_data_in    out  DATA_W  read data, valid the cycle after a_rd
//  busy         out  1       filter running
//  done         out  1       sticky; set at run end, cleared by next start or reset
//  irq          out  1       1-cycle pulse at run end
// BEHAVIOUR
//  Address map: 0x000 CTRL (wr bit0=1 -> start; rd {13'b0,err,busy,done}); 0x001 NTAPS; 0x002 NSAMPLES;
//   0x040-0x05F coeff h[k]; 0x400-0x7FF samples x[n]; 0x800-0xBFF results y[n] (read-only).
//   Unmapped reads return 0. Writes to unmapped or read-only addresses are dropped.
//  Reset: busy=done=irq=err=0, a_data_in=0, NTAPS=1, NSAMPLES=1, FSM=IDLE. Memories are not cleared.
//  Clamping on write: NTAPS 0->1, >MAX_TAPS->MAX_TAPS. NSAMPLES 0->1, >MAX_SAMPLES->MAX_SAMPLES.
//  FSM: IDLE -start-> LOAD (n=0) -> MAC -> STORE -> (n<NSAMPLES-1 ? LOAD : FINISH) -> IDLE.
//   LOAD: clear acc, k=0, issue the first memory reads. MAC: one tap/cycle, NTAPS cycles; memories
//   have registered 1-cycle read latency, so the pipeline is primed in LOAD. STORE: write sat(acc>>>15)
//   to y[n].
//  Timing: start write accepted at edge t -> busy=1 from t+1. busy stays high exactly
//   NSAMPLES*(NTAPS+2) cycles. In the cycle busy falls: done=1 and irq=1 for 1 cycle.
//  Arithmetic: signed 16x16 -> 32-bit product, sign-extended into ACC_W and summed. Result is
//   acc arithmetic-shifted right by 15 (truncation toward -inf), then saturated to [0x8000, 0x7FFF].
//   Terms with n-k<0 contribute 0, with no memory read side effect.
//  While busy:
//   - Writes to NTAPS, NSAMPLES, coeff or sample regions are dropped and set sticky err.
//   - A start write is ignored and does not set err.
//   - err clears on the next accepted start.
//   - Reads of CTRL/NTAPS/NSAMPLES are served normally. Result reads return current memory contents,
//     which may be partial.
//  Simultaneous a_wr and a_rd to the same register: read returns the pre-write value.
//  Reset mid-run: next cycle FSM=IDLE, busy=done=irq=err=0. Partial results remain in memory.
// STRUCTURE
//  fir_pkg: ADDR_W/DATA_W defaults, address-map constants (CTRL/NTAPS/NSAMPLES/COEF/SAMP/RES base
//   and size), state enum fir_state_t {IDLE, LOAD, MAC, STORE, FINISH}, CTRL bit positions.
//  Sub-module fir_mac: signed multiply, accumulate with clear/enable, shift and saturate output.
//  fir_core holds register decode, the three inferred RAMs, the FSM and the n/k counters.
// TESTING
//  1 Impulse: NTAPS=3, h={4000,2000,1000}h, x0=7FFFh, x1..3=0, NSAMPLES=4, start
//    -> y={3FFF,1FFF,0FFF,0000}h, busy 20 cycles, irq 1 pulse, done=1.
//  2 Saturation: NTAPS=2, h={7FFF,7FFF}h, x={7FFF,7FFF}h -> y={7FFE,7FFF}h.
//    Same with x={8000,8000}h -> y={8001,8000}h.
//  3 Write x0=1234h while busy -> sample memory unchanged, CTRL read shows err=1.
//    Next start clears err, and the result equals the pre-write run.
//  4 Reset pulse mid-run -> busy=done=0 next cycle. Rerun of test 1 gives identical results.
//  5 Clamp/readback: write NTAPS=0 -> reads 1. Write NTAPS=100 -> reads 32.
//    a_rd at cycle t -> a_data_in valid at t+1. Read 0x3FF -> 0.
//  6 Start while busy and start in the same cycle as irq -> ignored.
//    done stays 1, no second irq pulse.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, address map, CTRL bit positions and FSM state type for the FIR engine
package fir_pkg;
  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_MAX_TAPS = 32;
  localparam int DEF_MAX_SAMPLES = 1024;
  localparam int DEF_ACC_W = 40;
  localparam logic [12:0] CTRL_A = 13'h000;
  localparam logic [12:0] NTAPS_A = 13'h001;
  localparam logic [12:0] NSAMP_A = 13'h002;
  localparam logic [12:0] COEF_BASE = 13'h040;
  localparam logic [12:0] COEF_SIZE = 13'd32;
  localparam logic [12:0] SAMP_BASE = 13'h400;
  localparam logic [12:0] SAMP_SIZE = 13'd1024;
  localparam logic [12:0] RES_BASE = 13'h800;
  localparam logic [12:0] RES_SIZE = 13'd1024;
  localparam int CTRL_START = 0;
  localparam int CTRL_DONE = 0;
  localparam int CTRL_BUSY = 1;
  localparam int CTRL_ERR = 2;
  typedef enum logic [2:0] {IDLE, LOAD, MAC, STORE, FINISH} fir_state_t;
  function automatic logic in_rgn(input logic [12:0] a, input logic [12:0] base, input logic [12:0] size);
    return a >= base && a < base + size;
  endfunction
endpackage

// File: rtl/fir_mac.sv
// fir_mac: signed multiply-accumulate with clear/enable and Q1.15 shift-and-saturate output
module fir_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_h,
  input  logic signed [DATA_W-1:0] i_x,
  output logic        [DATA_W-1:0] o_y
);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 <<< (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_sh;
  logic signed [2*DATA_W-1:0] w_p;
  assign w_p = i_h * i_x;
  assign w_sh = r_acc >>> (DATA_W - 1);
  assign o_y = w_sh > MAXV ? MAXV[DATA_W-1:0] : w_sh < MINV ? MINV[DATA_W-1:0] : w_sh[DATA_W-1:0];
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) r_acc <= '0;
    else if (i_en) r_acc <= r_acc + {{(ACC_W-2*DATA_W){w_p[2*DATA_W-1]}}, w_p};
  end
endmodule

// File: rtl/fir_core.sv
// fir_core: register-mapped Q1.15 FIR engine with coefficient, sample and result memories
module fir_core
  import fir_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MAX_TAPS = DEF_MAX_TAPS,
  parameter int MAX_SAMPLES = DEF_MAX_SAMPLES,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic              a_clk,
  input  logic              a_rst_n,
  input  logic              a_wr,
  input  logic [ADDR_W-1:0] a_address_wr,
  input  logic [DATA_W-1:0] a_data_out,
  input  logic              a_rd,
  input  logic [ADDR_W-1:0] a_address_rd,
  output logic [DATA_W-1:0] a_data_in,
  output logic              busy,
  output logic              done,
  output logic              irq
);
  localparam int KW = $clog2(MAX_TAPS);
  localparam int TW = KW + 1;
  localparam int NW = $clog2(MAX_SAMPLES);
  localparam int SW = NW + 1;
  fir_state_t r_state, w_next;
  logic [DATA_W-1:0] r_coef [MAX_TAPS];
  logic [DATA_W-1:0] r_samp [MAX_SAMPLES];
  logic [DATA_W-1:0] r_res [MAX_SAMPLES];
  logic [TW-1:0] r_ntaps, w_ntaps_cl, w_tap;
  logic [SW-1:0] r_nsamp, w_nsamp_cl;
  logic [NW-1:0] r_n, w_xa;
  logic [KW-1:0] r_k;
  logic [DATA_W-1:0] r_h, r_x, w_y, w_rdata;
  logic r_err, r_done, r_vld;
  logic w_busy, w_start, w_wcoef, w_wsamp, w_wcfg, w_we, w_fetch, w_last_k, w_last_n;
  assign w_wcoef = in_rgn(a_address_wr, COEF_BASE, COEF_SIZE);
  assign w_wsamp = in_rgn(a_address_wr, SAMP_BASE, SAMP_SIZE);
  assign w_wcfg = a_wr && (a_address_wr == NTAPS_A || a_address_wr == NSAMP_A || w_wcoef || w_wsamp);
  assign w_we = w_wcfg && !w_busy;
  assign w_start = a_wr && a_address_wr == CTRL_A && a_data_out[CTRL_START] && r_state == IDLE;
  assign w_ntaps_cl = a_data_out == '0 ? TW'(1) : a_data_out > DATA_W'(MAX_TAPS) ? TW'(MAX_TAPS) : a_data_out[TW-1:0];
  assign w_nsamp_cl = a_data_out == '0 ? SW'(1) : a_data_out > DATA_W'(MAX_SAMPLES) ? SW'(MAX_SAMPLES) : a_data_out[SW-1:0];
  // r_k is the tap being accumulated; the fetch runs one tap ahead to cover the RAM read latency
  assign w_tap = r_state == LOAD ? '0 : {1'b0, r_k} + TW'(1);
  assign w_fetch = (r_state == LOAD || r_state == MAC) && w_tap < r_ntaps && NW'(w_tap) <= r_n;
  assign w_xa = r_n - NW'(w_tap);
  assign w_last_k = r_k == KW'(r_ntaps - TW'(1));
  assign w_last_n = SW'(r_n) == r_nsamp - SW'(1);
  assign w_rdata = a_address_rd == CTRL_A ? DATA_W'({r_err, w_busy, r_done}) :
                   a_address_rd == NTAPS_A ? DATA_W'(r_ntaps) :
                   a_address_rd == NSAMP_A ? DATA_W'(r_nsamp) :
                   in_rgn(a_address_rd, COEF_BASE, COEF_SIZE) ? r_coef[a_address_rd[KW-1:0]] :
                   in_rgn(a_address_rd, SAMP_BASE, SAMP_SIZE) ? r_samp[a_address_rd[NW-1:0]] :
                   in_rgn(a_address_rd, RES_BASE, RES_SIZE) ? r_res[a_address_rd[NW-1:0]] : '0;
  assign busy = w_busy;
  assign done = r_done;
  always_comb begin
    w_next = r_state;
    w_busy = r_state == LOAD || r_state == MAC || r_state == STORE;
    irq = r_state == FINISH;
    case (r_state)
      IDLE: w_next = w_start ? LOAD : IDLE;
      LOAD: w_next = MAC;
      MAC: w_next = w_last_k ? STORE : MAC;
      STORE: w_next = w_last_n ? FINISH : LOAD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge a_clk) begin
    if (!a_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge a_clk) begin
    if (!a_rst_n) begin
      r_ntaps <= TW'(1);
      r_nsamp <= SW'(1);
      r_err <= 1'b0;
      r_done <= 1'b0;
      r_n <= '0;
      r_k <= '0;
      r_vld <= 1'b0;
      a_data_in <= '0;
    end else begin
      if (w_we && a_address_wr == NTAPS_A) r_ntaps <= w_ntaps_cl;
      if (w_we && a_address_wr == NSAMP_A) r_nsamp <= w_nsamp_cl;
      if (w_start) r_err <= 1'b0;
      else if (w_wcfg && w_busy) r_err <= 1'b1;
      if (w_start) r_done <= 1'b0;
      else if (r_state == STORE && w_last_n) r_done <= 1'b1;
      r_n <= w_start ? '0 : r_state == STORE ? r_n + NW'(1) : r_n;
      r_k <= r_state == MAC ? r_k + KW'(1) : '0;
      r_vld <= w_fetch;
      if (a_rd) a_data_in <= w_rdata;
    end
  end
  always_ff @(posedge a_clk) begin
    if (w_we && w_wcoef) r_coef[a_address_wr[KW-1:0]] <= a_data_out;
    if (w_we && w_wsamp) r_samp[a_address_wr[NW-1:0]] <= a_data_out;
    if (r_state == STORE) r_res[r_n] <= w_y;
    if (w_fetch) begin
      r_h <= r_coef[w_tap[KW-1:0]];
      r_x <= r_samp[w_xa];
    end
  end
  fir_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .i_clk(a_clk),
    .i_rst_n(a_rst_n),
    .i_clr(r_state == LOAD),
    .i_en(r_state == MAC && r_vld),
    .i_h(r_h),
    .i_x(r_x),
    .o_y(w_y)
  );
endmodule

// File: tb/tb_fir_core.sv
// tb_fir_core: directed self-checking bench for fir_core
module tb_fir_core;
  logic a_clk = 1'b0;
  logic a_rst_n, a_wr, a_rd, busy, done, irq;
  logic [12:0] a_address_wr, a_address_rd;
  logic [15:0] a_data_out, a_data_in;
  int checks = 0;
  int errors = 0;
  int irq_cnt = 0;
  logic [15:0] imp_y [4] = '{16'h3FFF, 16'h1FFF, 16'h0FFF, 16'h0000};
  fir_core dut (
    .a_clk(a_clk),
    .a_rst_n(a_rst_n),
    .a_wr(a_wr),
    .a_address_wr(a_address_wr),
    .a_data_out(a_data_out),
    .a_rd(a_rd),
    .a_address_rd(a_address_rd),
    .a_data_in(a_data_in),
    .busy(busy),
    .done(done),
    .irq(irq)
  );
  always #5 a_clk = ~a_clk;
  always @(negedge a_clk) if (irq === 1'b1) irq_cnt++;
  task automatic wr(input logic [12:0] a, input logic [15:0] d);
    @(negedge a_clk);
    a_wr = 1'b1;
    a_address_wr = a;
    a_data_out = d;
    @(negedge a_clk);
    a_wr = 1'b0;
  endtask
  task automatic rd(input logic [12:0] a, output logic [15:0] d);
    @(negedge a_clk);
    a_rd = 1'b1;
    a_address_rd = a;
    @(negedge a_clk);
    a_rd = 1'b0;
    d = a_data_in;
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 500) begin
      n++;
      @(negedge a_clk);
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL busy_timeout: busy still %b after %0d cycles, required 0", busy, n);
    end
  endtask
  task automatic load_impulse;
    wr(13'h001, 16'd3);
    wr(13'h002, 16'd4);
    wr(13'h040, 16'h4000);
    wr(13'h041, 16'h2000);
    wr(13'h042, 16'h1000);
    wr(13'h400, 16'h7FFF);
    wr(13'h401, 16'h0000);
    wr(13'h402, 16'h0000);
    wr(13'h403, 16'h0000);
  endtask
  task automatic test_reset;
    logic [15:0] d;
    a_rst_n = 1'b0;
    a_wr = 1'b0;
    a_rd = 1'b0;
    a_address_wr = '0;
    a_address_rd = '0;
    a_data_out = '0;
    repeat (3) @(negedge a_clk);
    checks++;
    if ({busy, done, irq} !== 3'b000 || a_data_in !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: busy/done/irq=%b data=%h, required 000 and 0000", {busy, done, irq}, a_data_in);
    end
    a_rst_n = 1'b1;
    rd(13'h000, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL reset_ctrl: got %h, required 0000", d); end
    rd(13'h001, d);
    checks++;
    if (d !== 16'h0001) begin errors++; $display("FAIL reset_ntaps: got %h, required 0001", d); end
    rd(13'h002, d);
    checks++;
    if (d !== 16'h0001) begin errors++; $display("FAIL reset_nsamples: got %h, required 0001", d); end
  endtask
  task automatic test_impulse;
    int n;
    logic [15:0] d;
    load_impulse();
    irq_cnt = 0;
    wr(13'h000, 16'h0001);
    wait_idle(n);
    checks++;
    if (n !== 20) begin errors++; $display("FAIL impulse_busy_cycles: got %0d, required 20", n); end
    checks++;
    if (irq !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL impulse_end_flags: irq=%b done=%b, required 1 1", irq, done);
    end
    @(negedge a_clk);
    checks++;
    if (irq !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL impulse_irq_width: irq=%b done=%b, required 0 1", irq, done);
    end
    checks++;
    if (irq_cnt !== 1) begin errors++; $display("FAIL impulse_irq_count: got %0d, required 1", irq_cnt); end
    for (int i = 0; i < 4; i++) begin
      rd(13'h800 + 13'(i), d);
      checks++;
      if (d !== imp_y[i]) begin errors++; $display("FAIL impulse_y%0d: got %h, required %h", i, d, imp_y[i]); end
    end
  endtask
  task automatic test_saturation;
    int n;
    logic [15:0] d;
    wr(13'h001, 16'd2);
    wr(13'h002, 16'd2);
    wr(13'h040, 16'h7FFF);
    wr(13'h041, 16'h7FFF);
    wr(13'h400, 16'h7FFF);
    wr(13'h401, 16'h7FFF);
    wr(13'h000, 16'h0001);
    wait_idle(n);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL sat_busy_cycles: got %0d, required 8", n); end
    rd(13'h800, d);
    checks++;
    if (d !== 16'h7FFE) begin errors++; $display("FAIL sat_pos_y0: got %h, required 7ffe", d); end
    rd(13'h801, d);
    checks++;
    if (d !== 16'h7FFF) begin errors++; $display("FAIL sat_pos_y1: got %h, required 7fff", d); end
    wr(13'h400, 16'h8000);
    wr(13'h401, 16'h8000);
    wr(13'h000, 16'h0001);
    wait_idle(n);
    rd(13'h800, d);
    checks++;
    if (d !== 16'h8001) begin errors++; $display("FAIL sat_neg_y0: got %h, required 8001", d); end
    rd(13'h801, d);
    checks++;
    if (d !== 16'h8000) begin errors++; $display("FAIL sat_neg_y1: got %h, required 8000", d); end
  endtask
  task automatic test_busy_write;
    int n;
    logic [15:0] d;
    load_impulse();
    wr(13'h000, 16'h0001);
    repeat (2) @(negedge a_clk);
    wr(13'h400, 16'h1234);
    wr(13'h001, 16'd5);
    rd(13'h000, d);
    checks++;
    if (d !== 16'h0006) begin errors++; $display("FAIL busy_wr_ctrl_running: got %h, required 0006", d); end
    wait_idle(n);
    rd(13'h000, d);
    checks++;
    if (d !== 16'h0005) begin errors++; $display("FAIL busy_wr_ctrl_after: got %h, required 0005", d); end
    rd(13'h400, d);
    checks++;
    if (d !== 16'h7FFF) begin errors++; $display("FAIL busy_wr_sample_kept: got %h, required 7fff", d); end
    rd(13'h001, d);
    checks++;
    if (d !== 16'h0003) begin errors++; $display("FAIL busy_wr_ntaps_kept: got %h, required 0003", d); end
    wr(13'h000, 16'h0001);
    rd(13'h000, d);
    checks++;
    if (d !== 16'h0002) begin errors++; $display("FAIL busy_wr_err_cleared: got %h, required 0002", d); end
    wait_idle(n);
    rd(13'h000, d);
    checks++;
    if (d !== 16'h0001) begin errors++; $display("FAIL busy_wr_ctrl_done: got %h, required 0001", d); end
    for (int i = 0; i < 4; i++) begin
      rd(13'h800 + 13'(i), d);
      checks++;
      if (d !== imp_y[i]) begin errors++; $display("FAIL busy_wr_y%0d: got %h, required %h", i, d, imp_y[i]); end
    end
  endtask
  task automatic test_reset_mid_run;
    int n;
    logic [15:0] d;
    wr(13'h000, 16'h0001);
    repeat (6) @(negedge a_clk);
    a_rst_n = 1'b0;
    @(negedge a_clk);
    a_rst_n = 1'b1;
    checks++;
    if ({busy, done, irq} !== 3'b000) begin
      errors++;
      $display("FAIL midrun_reset_flags: busy/done/irq=%b, required 000", {busy, done, irq});
    end
    rd(13'h001, d);
    checks++;
    if (d !== 16'h0001) begin errors++; $display("FAIL midrun_reset_ntaps: got %h, required 0001", d); end
    load_impulse();
    wr(13'h000, 16'h0001);
    wait_idle(n);
    checks++;
    if (n !== 20) begin errors++; $display("FAIL midrun_rerun_cycles: got %0d, required 20", n); end
    for (int i = 0; i < 4; i++) begin
      rd(13'h800 + 13'(i), d);
      checks++;
      if (d !== imp_y[i]) begin errors++; $display("FAIL midrun_rerun_y%0d: got %h, required %h", i, d, imp_y[i]); end
    end
  endtask
  task automatic test_clamp_readback;
    logic [15:0] d;
    logic [12:0] addr [8] = '{13'h001, 13'h001, 13'h001, 13'h001, 13'h002, 13'h002, 13'h002, 13'h002};
    logic [15:0] wval [8] = '{16'd0, 16'd100, 16'd32, 16'd33, 16'd0, 16'd2000, 16'd1024, 16'd1025};
    logic [15:0] rexp [8] = '{16'd1, 16'd32, 16'd32, 16'd32, 16'd1, 16'd1024, 16'd1024, 16'd1024};
    for (int i = 0; i < 8; i++) begin
      wr(addr[i], wval[i]);
      rd(addr[i], d);
      checks++;
      if (d !== rexp[i]) begin
        errors++;
        $display("FAIL clamp_%0d: addr %h wrote %0d read %0d, required %0d", i, addr[i], wval[i], d, rexp[i]);
      end
    end
    rd(13'h3FF, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL unmapped_read: got %h, required 0000", d); end
    rd(13'h040, d);
    checks++;
    if (d !== 16'h4000) begin errors++; $display("FAIL coef_readback: got %h, required 4000", d); end
    wr(13'h800, 16'h1111);
    rd(13'h800, d);
    checks++;
    if (d !== 16'h3FFF) begin errors++; $display("FAIL result_readonly: got %h, required 3fff", d); end
    @(negedge a_clk);
    a_wr = 1'b1;
    a_address_wr = 13'h001;
    a_data_out = 16'd7;
    a_rd = 1'b1;
    a_address_rd = 13'h001;
    @(negedge a_clk);
    a_wr = 1'b0;
    a_rd = 1'b0;
    checks++;
    if (a_data_in !== 16'd32) begin errors++; $display("FAIL same_cycle_rd_wr: got %0d, required 32", a_data_in); end
    rd(13'h001, d);
    checks++;
    if (d !== 16'd7) begin errors++; $display("FAIL same_cycle_after: got %0d, required 7", d); end
  endtask
  task automatic test_start_ignored;
    int n;
    logic [15:0] d;
    wr(13'h001, 16'd3);
    wr(13'h002, 16'd4);
    irq_cnt = 0;
    wr(13'h000, 16'h0001);
    repeat (3) @(negedge a_clk);
    wr(13'h000, 16'h0001);
    wait_idle(n);
    checks++;
    if (n !== 15) begin errors++; $display("FAIL restart_busy_remaining: got %0d, required 15", n); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL restart_irq_cycle: irq=%b, required 1", irq); end
    a_wr = 1'b1;
    a_address_wr = 13'h000;
    a_data_out = 16'h0001;
    @(negedge a_clk);
    a_wr = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL start_on_irq: busy=%b done=%b, required 0 1", busy, done);
    end
    repeat (4) @(negedge a_clk);
    checks++;
    if (busy !== 1'b0 || irq_cnt !== 1) begin
      errors++;
      $display("FAIL start_ignored_quiet: busy=%b irq_count=%0d, required 0 1", busy, irq_cnt);
    end
    rd(13'h000, d);
    checks++;
    if (d !== 16'h0001) begin errors++; $display("FAIL start_ignored_ctrl: got %h, required 0001", d); end
  endtask
  initial begin
    test_reset();
    test_impulse();
    test_saturation();
    test_busy_write();
    test_reset_mid_run();
    test_clamp_readback();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
